// File: rtl/xaui_link_sequencer.sv
// rtl/xaui_link_sequencer.sv - XAUI 4-lane MGT bring-up, channel bonding and link supervision
module xaui_link_sequencer #(
    parameter int RESET_CYCLES  = 64,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int ALIGN_TIMEOUT = 50000,
    parameter int CHSYNC_CYCLES = 256,
    parameter int ERR_WINDOW    = 1024,
    parameter int ERR_THRESH    = 16
) (
    input  logic       mgt_clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [3:0] mgt_rxlock,
    input  logic [3:0] mgt_syncok,
    input  logic [7:0] mgt_codevalid,
    input  logic [3:0] mgt_rxbufferr,
    output logic [3:0] mgt_tx_reset,
    output logic [3:0] mgt_rx_reset,
    output logic [3:0] mgt_enable_align,
    output logic       mgt_enchansync,
    output logic       link_up,
    output logic [2:0] state,
    output logic [7:0] retry_count
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TX_RST    = 3'd1,
        ST_RX_RST    = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_ALIGN     = 3'd4,
        ST_CHSYNC    = 3'd5,
        ST_UP        = 3'd6
    } state_e;

    // Timer loads N-1 so that a state lasts exactly N cycles before its timeout edge.
    localparam logic [15:0] RESET_LOAD  = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] LOCK_LOAD   = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] ALIGN_LOAD  = 16'(ALIGN_TIMEOUT - 1);
    localparam logic [15:0] CHSYNC_LOAD = 16'(CHSYNC_CYCLES - 1);
    localparam logic [15:0] WINDOW_LOAD = 16'(ERR_WINDOW - 1);
    localparam logic [16:0] ERR_LIMIT   = 17'(ERR_THRESH);

    logic [3:0]  rxlock_q, syncok_q, rxbufferr_q;
    logic [7:0]  codevalid_q;
    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] err_q, err_d;
    logic [7:0]  retry_q, retry_d;
    logic [3:0]  tx_reset_q, tx_reset_d;
    logic [3:0]  rx_reset_q, rx_reset_d;
    logic [3:0]  align_q, align_d;
    logic        chsync_q, chsync_d;
    logic        link_q, link_d;
    logic        lock_all, sync_all, errored, timer_done, do_retry;
    logic [16:0] err_next;

    assign lock_all   = &rxlock_q;
    assign sync_all   = &syncok_q;
    assign errored    = (~&codevalid_q) | (|rxbufferr_q);
    assign timer_done = (timer_q == 16'd0);
    assign err_next   = {1'b0, err_q} + {16'd0, errored};

    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        err_d      = '0;
        timer_d    = timer_q;
        do_retry   = 1'b0;

        // Success is tested before timeout so a coincident pair resolves to success.
        case (state_q)
            ST_IDLE:      if (enable) state_d = ST_TX_RST;
            ST_TX_RST:    if (timer_done) state_d = ST_RX_RST;
            ST_RX_RST:    if (timer_done) state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (lock_all)        state_d  = ST_ALIGN;
                else if (timer_done) do_retry = 1'b1;
            end
            ST_ALIGN: begin
                if (sync_all)        state_d  = ST_CHSYNC;
                else if (timer_done) do_retry = 1'b1;
            end
            ST_CHSYNC: begin
                if (errored || !sync_all) do_retry = 1'b1;
                else if (timer_done)      state_d  = ST_UP;
            end
            ST_UP: begin
                if (err_next >= ERR_LIMIT || !lock_all || !sync_all) do_retry = 1'b1;
                else if (!timer_done)                                 err_d    = err_next[15:0];
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_retry) begin
            state_d = ST_TX_RST;
            if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
        end

        if (!enable) begin
            state_d = ST_IDLE;
            retry_d = retry_q;
            err_d   = '0;
        end

        if (state_d != state_q) begin
            case (state_d)
                ST_TX_RST, ST_RX_RST: timer_d = RESET_LOAD;
                ST_WAIT_LOCK:         timer_d = LOCK_LOAD;
                ST_ALIGN:             timer_d = ALIGN_LOAD;
                ST_CHSYNC:            timer_d = CHSYNC_LOAD;
                ST_UP:                timer_d = WINDOW_LOAD;
                default:              timer_d = 16'd0;
            endcase
        end else if (timer_done) begin
            timer_d = (state_q == ST_UP) ? WINDOW_LOAD : 16'd0;
        end else begin
            timer_d = timer_q - 16'd1;
        end

        tx_reset_d = (state_d == ST_IDLE || state_d == ST_TX_RST) ? 4'hF : 4'h0;
        rx_reset_d = (state_d == ST_IDLE || state_d == ST_TX_RST || state_d == ST_RX_RST) ? 4'hF : 4'h0;
        align_d    = (state_d == ST_ALIGN || state_d == ST_CHSYNC || state_d == ST_UP) ? 4'hF : 4'h0;
        chsync_d   = (state_d == ST_CHSYNC || state_d == ST_UP);
        link_d     = (state_d == ST_UP);
    end

    always_ff @(posedge mgt_clk or negedge reset_n) begin
        if (!reset_n) begin
            rxlock_q    <= '0;
            syncok_q    <= '0;
            codevalid_q <= '0;
            rxbufferr_q <= '0;
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            err_q       <= '0;
            retry_q     <= '0;
            tx_reset_q  <= 4'hF;
            rx_reset_q  <= 4'hF;
            align_q     <= 4'h0;
            chsync_q    <= 1'b0;
            link_q      <= 1'b0;
        end else begin
            rxlock_q    <= mgt_rxlock;
            syncok_q    <= mgt_syncok;
            codevalid_q <= mgt_codevalid;
            rxbufferr_q <= mgt_rxbufferr;
            state_q     <= state_d;
            timer_q     <= timer_d;
            err_q       <= err_d;
            retry_q     <= retry_d;
            tx_reset_q  <= tx_reset_d;
            rx_reset_q  <= rx_reset_d;
            align_q     <= align_d;
            chsync_q    <= chsync_d;
            link_q      <= link_d;
        end
    end

    assign mgt_tx_reset     = tx_reset_q;
    assign mgt_rx_reset     = rx_reset_q;
    assign mgt_enable_align = align_q;
    assign mgt_enchansync   = chsync_q;
    assign link_up          = link_q;
    assign state            = state_q;
    assign retry_count      = retry_q;

endmodule

// File: tb/tb_xaui_link_sequencer.sv
// tb/tb_xaui_link_sequencer.sv - self-checking bench for xaui_link_sequencer
module tb_xaui_link_sequencer;

    localparam int RC = 4;
    localparam int LT = 100;
    localparam int AT = 100;
    localparam int CC = 8;
    localparam int EW = 16;
    localparam int ET = 3;
    localparam int NW = 5;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TX_RST    = 3'd1;
    localparam logic [2:0] S_RX_RST    = 3'd2;
    localparam logic [2:0] S_WAIT_LOCK = 3'd3;
    localparam logic [2:0] S_ALIGN     = 3'd4;
    localparam logic [2:0] S_CHSYNC    = 3'd5;
    localparam logic [2:0] S_UP        = 3'd6;

    logic       mgt_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable  = 1'b0;
    logic [3:0] mgt_rxlock    = 4'hF;
    logic [3:0] mgt_syncok    = 4'hF;
    logic [7:0] mgt_codevalid = 8'hFF;
    logic [3:0] mgt_rxbufferr = 4'h0;
    logic [3:0] mgt_tx_reset, mgt_rx_reset, mgt_enable_align;
    logic       mgt_enchansync, link_up;
    logic [2:0] state;
    logic [7:0] retry_count;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_retry = 0;

    always #5 mgt_clk = ~mgt_clk;

    xaui_link_sequencer #(
        .RESET_CYCLES (RC),
        .LOCK_TIMEOUT (LT),
        .ALIGN_TIMEOUT(AT),
        .CHSYNC_CYCLES(CC),
        .ERR_WINDOW   (EW),
        .ERR_THRESH   (ET)
    ) dut (
        .mgt_clk         (mgt_clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .mgt_rxlock      (mgt_rxlock),
        .mgt_syncok      (mgt_syncok),
        .mgt_codevalid   (mgt_codevalid),
        .mgt_rxbufferr   (mgt_rxbufferr),
        .mgt_tx_reset    (mgt_tx_reset),
        .mgt_rx_reset    (mgt_rx_reset),
        .mgt_enable_align(mgt_enable_align),
        .mgt_enchansync  (mgt_enchansync),
        .link_up         (link_up),
        .state           (state),
        .retry_count     (retry_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected outputs for a given state, straight from the state table.
    task automatic check_outs(input string tag, input logic [2:0] s);
        check({tag, "_state"},  32'(state), 32'(s));
        check({tag, "_tx"},     32'(mgt_tx_reset),     (s <= S_TX_RST) ? 32'hF : 32'h0);
        check({tag, "_rx"},     32'(mgt_rx_reset),     (s <= S_RX_RST) ? 32'hF : 32'h0);
        check({tag, "_align"},  32'(mgt_enable_align), (s >= S_ALIGN)  ? 32'hF : 32'h0);
        check({tag, "_chsync"}, 32'(mgt_enchansync),   (s >= S_CHSYNC) ? 32'h1 : 32'h0);
        check({tag, "_link"},   32'(link_up),          (s == S_UP)     ? 32'h1 : 32'h0);
    endtask

    task automatic tick();
        @(posedge mgt_clk);
        #1;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        int n;
        n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    function automatic logic [2:0] nominal_state(input int e);
        if (e <= RC)               return S_TX_RST;
        if (e <= 2 * RC)           return S_RX_RST;
        if (e == 2 * RC + 1)       return S_WAIT_LOCK;
        if (e == 2 * RC + 2)       return S_ALIGN;
        if (e <= 2 * RC + 2 + CC)  return S_CHSYNC;
        return S_UP;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n_iter, retry_k, w, need, placed, p;
        int cnt [NW];
        bit err_slot [NW*EW];

        // Reset state
        repeat (3) tick();
        check_outs("reset", S_IDLE);
        check("reset_retry", 32'(retry_count), 0);
        reset_n = 1'b1;
        tick();
        tick();
        check("idle_hold", 32'(state), 32'(S_IDLE));

        // Nominal bring-up
        enable = 1'b1;
        for (int e = 1; e <= 2 * RC + CC + 4; e++) begin
            tick();
            check_outs($sformatf("nominal_e%0d", e), nominal_state(e));
        end
        check("nominal_retry", 32'(retry_count), 0);

        // Single-cycle lane loss in UP
        repeat ($urandom_range(2, 10)) tick();
        mgt_syncok = 4'b1011;
        tick();
        mgt_syncok = 4'hF;
        check("laneloss_hold", 32'(state), 32'(S_UP));
        tick();
        exp_retry++;
        check_outs("laneloss", S_TX_RST);
        check("laneloss_retry", 32'(retry_count), 32'(exp_retry));

        // Error threshold: 2 errors per window for 4 windows, then 3 in one window
        wait_state("thr_up", S_UP, 300);
        for (int i = 0; i < NW * EW; i++) err_slot[i] = 1'b0;
        for (int i = 0; i < NW; i++) cnt[i] = 0;
        for (int wi = 0; wi < NW; wi++) begin
            need = (wi < NW - 1) ? 2 : ET;
            placed = 0;
            while (placed < need) begin
                p = $urandom_range(1, EW - 1);
                if (!err_slot[wi * EW + p - 1]) begin
                    err_slot[wi * EW + p - 1] = 1'b1;
                    placed++;
                end
            end
        end
        // Input slot k lands in error window (k+1)/EW counted from UP entry.
        retry_k = -1;
        for (int k = 0; k < NW * EW; k++) begin
            if (err_slot[k]) begin
                w = (k + 1) / EW;
                cnt[w]++;
                if (cnt[w] == ET && retry_k < 0) retry_k = k;
            end
        end
        for (int k = 0; k <= retry_k + 1; k++) begin
            mgt_codevalid = 8'hFF;
            mgt_rxbufferr = 4'h0;
            if (err_slot[k]) begin
                if ($urandom_range(0, 1) == 1) mgt_codevalid = ~(8'(1) << $urandom_range(0, 7));
                else                           mgt_rxbufferr = 4'(1) << $urandom_range(0, 3);
            end
            tick();
            if (k == retry_k + 1) begin
                exp_retry++;
                check_outs("thr_retry", S_TX_RST);
                check("thr_retry_cnt", 32'(retry_count), 32'(exp_retry));
            end else begin
                check($sformatf("thr_up_k%0d", k), 32'(state), 32'(S_UP));
                check($sformatf("thr_link_k%0d", k), 32'(link_up), 1);
            end
        end
        mgt_codevalid = 8'hFF;
        mgt_rxbufferr = 4'h0;

        // Enable drop mid-ALIGN
        mgt_syncok = 4'h7;
        wait_state("endrop_align", S_ALIGN, 300);
        repeat (3) tick();
        enable = 1'b0;
        tick();
        check_outs("endrop", S_IDLE);
        check("endrop_retry", 32'(retry_count), 32'(exp_retry));
        enable = 1'b1;
        tick();
        check("endrop_restart", 32'(state), 32'(S_TX_RST));
        mgt_syncok = 4'hF;

        // Lock arriving on the timeout cycle resolves to success
        mgt_rxlock = 4'hE;
        wait_state("lk98_wait", S_WAIT_LOCK, 300);
        repeat (LT - 2) tick();
        mgt_rxlock = 4'hF;
        tick();
        check("lk98_before", 32'(state), 32'(S_WAIT_LOCK));
        tick();
        check("lk98_success", 32'(state), 32'(S_ALIGN));
        check("lk98_retry", 32'(retry_count), 32'(exp_retry));

        // Lock loss in UP
        mgt_rxlock = 4'hE;
        wait_state("uplock_up", S_UP, 300);
        tick();
        exp_retry++;
        check("uplock_state", 32'(state), 32'(S_TX_RST));
        check("uplock_retry", 32'(retry_count), 32'(exp_retry));

        // Lock one cycle too late times out
        wait_state("lk99_wait", S_WAIT_LOCK, 300);
        repeat (LT - 1) tick();
        check("lk99_before", 32'(state), 32'(S_WAIT_LOCK));
        mgt_rxlock = 4'hF;
        tick();
        exp_retry++;
        check("lk99_timeout", 32'(state), 32'(S_TX_RST));
        check("lk99_retry", 32'(retry_count), 32'(exp_retry));

        // Repeated lock timeouts until retry_count saturates
        mgt_rxlock = 4'hE;
        n_iter = 255 - exp_retry + 2;
        for (int i = 0; i < n_iter; i++) begin
            wait_state("sat_wait", S_WAIT_LOCK, 50);
            n = 0;
            while (state === S_WAIT_LOCK && n < 2 * LT) begin
                tick();
                n++;
            end
            check($sformatf("sat_len_%0d", i), 32'(n), 32'(LT));
            check($sformatf("sat_state_%0d", i), 32'(state), 32'(S_TX_RST));
            if (exp_retry < 255) exp_retry++;
            check($sformatf("sat_retry_%0d", i), 32'(retry_count), 32'(exp_retry));
        end

        // Asynchronous reset pulse during CHSYNC
        mgt_rxlock = 4'hF;
        wait_state("areset_ch", S_CHSYNC, 300);
        repeat (3) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check_outs("areset", S_IDLE);
        check("areset_retry", 32'(retry_count), 0);
        tick();
        reset_n = 1'b1;
        check("areset_hold", 32'(state), 32'(S_IDLE));
        tick();
        check("areset_restart", 32'(state), 32'(S_TX_RST));
        check("areset_retry_after", 32'(retry_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/xaui_link_sequencer.md
# xaui_link_sequencer

Bring-up and supervision controller for one 4-lane XAUI MGT port of the ROACH XAUI infrastructure. It sequences the per-lane TX/RX resets, comma alignment and channel bonding, then monitors lock, sync and code-error status. On any failure it retries the bring-up. One instance drives the `mgt_tx_reset_N`, `mgt_rx_reset_N`, `mgt_enable_align_N` and `mgt_enchansync_N` controls of one enabled port, and it lives in that port's `mgt_clk` domain.

## Interface
- `RESET_CYCLES`, 64: cycles spent in each of the TX and RX reset phases (1..65535).
- `LOCK_TIMEOUT`, 50000: maximum cycles to wait for all-lane `rxlock`.
- `ALIGN_TIMEOUT`, 50000: maximum cycles to wait for all-lane `syncok`.
- `CHSYNC_CYCLES`, 256: error-free cycles required in channel sync before the link is declared up.
- `ERR_WINDOW`, 1024: length of the error-counting window in UP.
- `ERR_THRESH`, 16: errored cycles within one window that force a retry (1..ERR_WINDOW).

Ports:
- `mgt_clk` in 1: port clock; all logic is in this domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run the link; 0 holds the port in IDLE.
- `mgt_rxlock` in 4: per-lane CDR lock.
- `mgt_syncok` in 4: per-lane comma alignment achieved.
- `mgt_codevalid` in 8: per-byte valid 8b/10b code.
- `mgt_rxbufferr` in 4: per-lane elastic buffer error.
- `mgt_tx_reset` out 4: per-lane TX reset, active-high.
- `mgt_rx_reset` out 4: per-lane RX reset, active-high.
- `mgt_enable_align` out 4: per-lane comma align enable.
- `mgt_enchansync` out 1: channel bonding enable.
- `link_up` out 1: the port is in UP.
- `state` out 3: current state encoding.
- `retry_count` out 8: number of retries since reset; saturates at 255.

## Operation
- The status inputs (`rxlock`, `syncok`, `codevalid`, `rxbufferr`) pass through one register stage. All decisions use these registered copies.
- State encodings: IDLE=0, TX_RST=1, RX_RST=2, WAIT_LOCK=3, ALIGN=4, CHSYNC=5, UP=6.
- A single 16-bit down-counter serves as the timer. It loads on every state entry.
- **IDLE:** tx_reset=rx_reset=4'hF, align=0, enchansync=0. If `enable`=1, go to TX_RST.
- **TX_RST:** tx_reset=rx_reset=4'hF. After RESET_CYCLES cycles, go to RX_RST.
- **RX_RST:** tx_reset=0, rx_reset=4'hF. After RESET_CYCLES cycles, go to WAIT_LOCK.
- **WAIT_LOCK:** all resets 0. If rxlock==4'hF, go to ALIGN. If LOCK_TIMEOUT cycles elapse first, retry.
- **ALIGN:** enable_align=4'hF. If syncok==4'hF, go to CHSYNC. If ALIGN_TIMEOUT cycles elapse first, retry.
- **CHSYNC:** enable_align=4'hF and enchansync=1.
  - If any cycle has codevalid!=8'hFF, rxbufferr!=0 or syncok!=4'hF, retry.
  - After CHSYNC_CYCLES clean cycles, go to UP.
- **UP:** link_up=1, with CHSYNC outputs held.
  - An errored cycle is one with codevalid!=8'hFF or rxbufferr!=0. The error counter increments on each errored cycle.
  - The window counter clears the error counter every ERR_WINDOW cycles.
  - The error counter is cleared on UP entry.
  - Retry when the error counter reaches ERR_THRESH, when rxlock!=4'hF, or when syncok!=4'hF.
- **Retry:** the next state is TX_RST and `retry_count` increments (saturating at 255).
- **enable=0:** from any state, the next state is IDLE; `retry_count` is unchanged. This has priority over all other transitions.
- Simultaneous events: the enable drop wins. A timeout and the success condition in the same cycle resolve to success. An error on the last CHSYNC cycle is a retry.
- `retry_count` is cleared only by `reset_n`.

## Timing
- Reset values: state=IDLE, mgt_tx_reset=4'hF, mgt_rx_reset=4'hF, mgt_enable_align=0, mgt_enchansync=0, link_up=0, retry_count=0. All counters are 0.
- All outputs are registered and change on the same edge as `state`.
- An input change reaches the state on the 2nd rising edge after it is presented (one register stage plus the FSM).
- `enable` is not registered. It takes effect on the next edge.
- An asynchronous `reset_n` assertion mid-operation immediately forces the reset values. Release is synchronous to `mgt_clk`; the integrator supplies a reset synchronizer.

## Test plan
1. **Nominal bring-up.** RESET_CYCLES=4, CHSYNC_CYCLES=8, all status good, enable rises before edge 1. Expect TX_RST for edges 1–4, RX_RST for 5–8, WAIT_LOCK at 9, ALIGN at 10, CHSYNC at 11, and link_up=1 from edge 19. retry_count stays 0.
2. **Lock timeout.** rxlock=4'hE held, LOCK_TIMEOUT=100. Expect exactly 100 cycles in WAIT_LOCK, then TX_RST with retry_count=1. Repeat until retry_count=255 and confirm it saturates.
3. **Error threshold.** In UP with ERR_THRESH=3 and ERR_WINDOW=16: 2 errored cycles per window leave the link up; 3 errored cycles within one window cause retry with link_up=0 on the next state edge.
4. **Lane loss in UP.** Drop `syncok[2]` for one cycle. Expect TX_RST two edges later and retry_count incremented.
5. **Enable drop mid-ALIGN.** Expect IDLE on the next edge with all resets at 4'hF and retry_count unchanged. Reasserting enable restarts at TX_RST.
6. **reset_n pulse during CHSYNC.** Expect all outputs at their reset values asynchronously, including retry_count=0.
